// File: rtl/mod_sinesched_if.sv
// Handshake/bus bundle for mod_sinesched: strobe and config in, shared-source
// operands out and sine back in, averaged mix and status flags out.
interface mod_sinesched_if #(
  parameter int N_VOICES = 4,
  parameter int VW       = $clog2(N_VOICES)
);
  logic                 i_sample_stb;
  logic                 i_cfg_we;
  logic [VW-1:0]        i_cfg_voice;
  logic [31:0]          i_cfg_period;
  logic                 i_cfg_enable;
  logic [63:0]          o_src_time;
  logic [31:0]          o_src_period;
  logic signed [31:0]   i_src_sine;
  logic signed [31:0]   o_mix;
  logic                 o_mix_valid;
  logic                 o_busy;
  logic                 o_overrun;

  modport master (
    output i_sample_stb, i_cfg_we, i_cfg_voice, i_cfg_period, i_cfg_enable, i_src_sine,
    input  o_src_time, o_src_period, o_mix, o_mix_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_sample_stb, i_cfg_we, i_cfg_voice, i_cfg_period, i_cfg_enable, i_src_sine,
    output o_src_time, o_src_period, o_mix, o_mix_valid, o_busy, o_overrun
  );
endinterface

// File: rtl/mod_sinesched.sv
// Time-multiplexes one shared sine source across N_VOICES voices and emits one
// averaged mix sample per frame (two cycles per voice, always, so frames are fixed-length).
module mod_sinesched #(
  parameter int N_VOICES = 4,
  parameter int VW       = $clog2(N_VOICES)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mod_sinesched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;

  logic [31:0]           period_r     [N_VOICES];
  logic [63:0]           time_r       [N_VOICES];
  logic [31:0]           cfg_period_r [N_VOICES];
  logic [N_VOICES-1:0]   enable_r;
  logic [N_VOICES-1:0]   cfg_enable_r;
  logic [N_VOICES-1:0]   restart_r;
  logic [VW-1:0]         idx_r;
  logic signed [31+VW:0] acc_r;

  logic [63:0]           src_time_r;
  logic [31:0]           src_period_r;
  logic signed [31:0]    mix_r;
  logic                  mix_valid_r;
  logic                  busy_r;
  logic                  overrun_r;

  logic                  live_s;
  logic                  last_s;
  logic [63:0]           time_inc_s;
  logic [63:0]           time_adv_s;
  logic signed [31+VW:0] sine_ext_s;

  // Current-voice helpers: liveness, last-slot flag and wrapped time advance
  always_comb begin
    live_s     = enable_r[idx_r] && (period_r[idx_r] != 32'd0);
    last_s     = (idx_r == VW'(N_VOICES - 1));
    time_inc_s = time_r[idx_r] + 64'd1;
    sine_ext_s = $signed({{VW{bus.i_src_sine[31]}}, bus.i_src_sine});
    if (time_inc_s >= {32'd0, period_r[idx_r]}) begin
      time_adv_s = 64'd0;
    end else begin
      time_adv_s = time_inc_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_sample_stb) begin
          state_nx_s = ST_PRESENT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PRESENT: state_nx_s = ST_ACCUM;
      ST_ACCUM: begin
        if (last_s) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_PRESENT;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Per-voice state, accumulator and registered outputs; config write lands last so it wins over the frame-start copy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int v = 0; v < N_VOICES; v++) begin
        period_r[v]     <= 32'd0;
        time_r[v]       <= 64'd0;
        cfg_period_r[v] <= 32'd0;
      end
      enable_r     <= '0;
      cfg_enable_r <= '0;
      restart_r    <= '0;
      idx_r        <= '0;
      acc_r        <= '0;
      src_time_r   <= 64'd0;
      src_period_r <= 32'd1;
      mix_r        <= 32'sd0;
      mix_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      mix_valid_r <= 1'b0;
      overrun_r   <= bus.i_sample_stb && (state_r != ST_IDLE);
      busy_r      <= (state_nx_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (bus.i_sample_stb) begin
            for (int v = 0; v < N_VOICES; v++) begin
              period_r[v] <= cfg_period_r[v];
              if (restart_r[v]) begin
                time_r[v] <= 64'd0;
              end
            end
            enable_r  <= cfg_enable_r;
            restart_r <= '0;
            acc_r     <= '0;
            idx_r     <= '0;
          end
        end
        ST_PRESENT: begin
          src_time_r   <= time_r[idx_r];
          src_period_r <= (period_r[idx_r] == 32'd0) ? 32'd1 : period_r[idx_r];
        end
        ST_ACCUM: begin
          if (live_s) begin
            acc_r         <= acc_r + sine_ext_s;
            time_r[idx_r] <= time_adv_s;
          end
          if (!last_s) begin
            idx_r <= idx_r + VW'(1);
          end
        end
        ST_DONE: begin
          // Taking bits [VW+31:VW] is the arithmetic shift by VW truncated to 32 bits
          mix_r       <= acc_r[VW +: 32];
          mix_valid_r <= 1'b1;
        end
        default: ;
      endcase
      if (bus.i_cfg_we) begin
        cfg_period_r[bus.i_cfg_voice] <= bus.i_cfg_period;
        cfg_enable_r[bus.i_cfg_voice] <= bus.i_cfg_enable;
        restart_r[bus.i_cfg_voice]    <= 1'b1;
      end
    end
  end

  assign bus.o_src_time   = src_time_r;
  assign bus.o_src_period = src_period_r;
  assign bus.o_mix        = mix_r;
  assign bus.o_mix_valid  = mix_valid_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_overrun    = overrun_r;

endmodule

// File: tb/tb_mod_sinesched.sv
// Self-checking bench for mod_sinesched: a table of single-voice frames, hand-written
// corner sequences, and randomized frames against a frame-level behavioural model.
module tb_mod_sinesched;
  localparam int N  = 4;
  localparam int VW = 2;
  localparam int FL = 2 * N + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_sinesched_if #(.N_VOICES(N)) bus ();
  mod_sinesched #(.N_VOICES(N)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  bit          sine_mode;
  logic [31:0] salt;

  // Stand-in for the shared source: extremes mode alternates +/-262136, else a hash
  function automatic logic signed [31:0] ref_sine(input logic [63:0] t, input logic [31:0] p,
                                                  input bit mode, input logic [31:0] s);
    logic [31:0] h;
    if (mode) return t[0] ? -32'sd262136 : 32'sd262136;
    h = (t[31:0] * 32'd2654435761) ^ (p * 32'd40503) ^ s;
    return $signed(h);
  endfunction

  always_comb bus.i_src_sine = ref_sine(bus.o_src_time, bus.o_src_period, sine_mode, salt);

  // Behavioural model: active and shadow config per voice
  logic [31:0] m_period[N], m_cfg_period[N];
  bit          m_enable[N], m_cfg_enable[N], m_restart[N];
  logic [63:0] m_time[N];
  logic [63:0] obs_time[N];
  logic [31:0] obs_period[N];

  function automatic void model_reset();
    for (int v = 0; v < N; v++) begin
      m_period[v] = 32'd0; m_cfg_period[v] = 32'd0;
      m_enable[v] = 1'b0;  m_cfg_enable[v] = 1'b0;
      m_restart[v] = 1'b0; m_time[v] = 64'd0;
    end
  endfunction

  function automatic void model_write(input int v, input logic [31:0] p, input bit e);
    m_cfg_period[v] = p;
    m_cfg_enable[v] = e;
    m_restart[v]    = 1'b1;
  endfunction

  function automatic void model_start();
    for (int v = 0; v < N; v++) begin
      m_period[v] = m_cfg_period[v];
      m_enable[v] = m_cfg_enable[v];
      if (m_restart[v]) begin
        m_time[v] = 64'd0;
        m_restart[v] = 1'b0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int v, input logic [31:0] p, input bit e);
    bus.i_cfg_we = 1'b1; bus.i_cfg_voice = VW'(v); bus.i_cfg_period = p; bus.i_cfg_enable = e;
    model_write(v, p, e);
    tick();
    bus.i_cfg_we = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_src_time"},   bus.o_src_time, 64'd0);
    chk({tag, "_src_period"}, 64'(bus.o_src_period), 64'd1);
    chk({tag, "_mix"},        64'(bus.o_mix), 64'd0);
    chk({tag, "_mix_valid"},  64'(bus.o_mix_valid), 64'd0);
    chk({tag, "_busy"},       64'(bus.o_busy), 64'd0);
    chk({tag, "_overrun"},    64'(bus.o_overrun), 64'd0);
  endtask

  // One frame: strobe in cycle 0, optional config write in cycle wcyc, optional extra strobe in cycle ocyc
  task automatic run_frame(input int wcyc, input int wv, input logic [31:0] wp, input bit we_,
                           input int ocyc);
    longint             sum;
    logic signed [31:0] exp_mix;
    int                 v;
    sum = 0;
    for (int c = 0; c <= FL; c++) begin
      bus.i_sample_stb  = (c == 0) || (c == ocyc);
      bus.i_cfg_we      = (c == wcyc);
      bus.i_cfg_voice   = VW'(wv);
      bus.i_cfg_period  = wp;
      bus.i_cfg_enable  = we_;
      if (c == 0) model_start();
      if (c == wcyc) model_write(wv, wp, we_);
      if (c >= 1) chk("overrun", 64'(bus.o_overrun), 64'((ocyc >= 0) && (c == ocyc + 1)));
      if (c >= 1 && c <= FL - 1) begin
        chk("busy_in_frame", 64'(bus.o_busy), 64'd1);
        chk("mix_valid_early", 64'(bus.o_mix_valid), 64'd0);
      end
      if (c >= 2 && c <= 2 * N && (c % 2) == 0) begin
        v = (c - 2) / 2;
        obs_time[v]   = bus.o_src_time;
        obs_period[v] = bus.o_src_period;
        chk("src_time", bus.o_src_time, m_time[v]);
        chk("src_period", 64'(bus.o_src_period), 64'((m_period[v] == 32'd0) ? 32'd1 : m_period[v]));
        if (m_enable[v] && m_period[v] != 32'd0) begin
          sum += longint'(ref_sine(m_time[v], m_period[v], sine_mode, salt));
          m_time[v] = (m_time[v] + 64'd1) % {32'd0, m_period[v]};
        end
      end
      if (c == FL) begin
        exp_mix = 32'(sum >>> VW);
        chk("mix_valid", 64'(bus.o_mix_valid), 64'd1);
        chk("mix", 64'(bus.o_mix), 64'(exp_mix));
        chk("busy_after_done", 64'(bus.o_busy), 64'd0);
      end
      tick();
    end
    bus.i_sample_stb = 1'b0;
    bus.i_cfg_we     = 1'b0;
    chk("mix_valid_single", 64'(bus.o_mix_valid), 64'd0);
  endtask

  typedef struct {
    bit          do_cfg;
    logic [31:0] cfg_period;
    bit          cfg_en;
    logic [63:0] exp_time;
    logic [31:0] exp_period;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 32'd4, 1'b1, 64'd0, 32'd4};
    vecs[1] = '{1'b0, 32'd0, 1'b0, 64'd1, 32'd4};
    vecs[2] = '{1'b0, 32'd0, 1'b0, 64'd2, 32'd4};
    vecs[3] = '{1'b0, 32'd0, 1'b0, 64'd3, 32'd4};
    vecs[4] = '{1'b0, 32'd0, 1'b0, 64'd0, 32'd4};
    vecs[5] = '{1'b0, 32'd0, 1'b0, 64'd1, 32'd4};
    vecs[6] = '{1'b1, 32'd2, 1'b1, 64'd0, 32'd2};
    vecs[7] = '{1'b0, 32'd0, 1'b0, 64'd1, 32'd2};
    vecs[8] = '{1'b1, 32'd2, 1'b0, 64'd0, 32'd2};
    vecs[9] = '{1'b0, 32'd0, 1'b0, 64'd0, 32'd2};

    bus.i_sample_stb = 1'b0; bus.i_cfg_we = 1'b0; bus.i_cfg_voice = '0;
    bus.i_cfg_period = 32'd0; bus.i_cfg_enable = 1'b0;
    sine_mode = 1'b0; salt = $urandom;
    model_reset();

    rst = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (20) begin
      tick();
      chk("idle_mix_valid", 64'(bus.o_mix_valid), 64'd0);
      chk("idle_busy", 64'(bus.o_busy), 64'd0);
    end

    // Single voice, table-driven
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_cfg) cfg_write(0, vecs[i].cfg_period, vecs[i].cfg_en);
      run_frame(-1, 0, 32'd0, 1'b0, -1);
      chk("tbl_v0_time", obs_time[0], vecs[i].exp_time);
      chk("tbl_v0_period", 64'(obs_period[0]), 64'(vecs[i].exp_period));
      tick();
    end

    // Two voices at the source extremes
    sine_mode = 1'b1;
    cfg_write(0, 32'd8, 1'b1);
    cfg_write(2, 32'd3, 1'b1);
    cfg_write(1, 32'd7, 1'b0);
    cfg_write(3, 32'd5, 1'b0);
    repeat (8) run_frame(-1, 0, 32'd0, 1'b0, -1);

    // Overrun mid-frame and in the DONE cycle
    sine_mode = 1'b0;
    run_frame(-1, 0, 32'd0, 1'b0, 4);
    run_frame(-1, 0, 32'd0, 1'b0, FL - 1);

    // Mid-frame config write takes effect next frame
    run_frame(3, 1, 32'd5, 1'b1, -1);
    chk("midcfg_old_period", 64'(obs_period[1]), 64'd7);
    run_frame(-1, 0, 32'd0, 1'b0, -1);
    chk("midcfg_new_time", obs_time[1], 64'd0);
    chk("midcfg_new_period", 64'(obs_period[1]), 64'd5);

    // Strobe and write in the same cycle
    run_frame(0, 2, 32'd6, 1'b1, -1);
    chk("samecyc_old_period", 64'(obs_period[2]), 64'd3);
    run_frame(-1, 0, 32'd0, 1'b0, -1);
    chk("samecyc_new_period", 64'(obs_period[2]), 64'd6);
    chk("samecyc_new_time", obs_time[2], 64'd0);

    // Enabled voice with zero period
    cfg_write(3, 32'd0, 1'b1);
    run_frame(-1, 0, 32'd0, 1'b0, -1);
    chk("zero_period_clamp", 64'(obs_period[3]), 64'd1);

    // Randomized frames
    repeat (40) begin
      int wcyc, ocyc, wv;
      logic [31:0] wp;
      sine_mode = 1'($urandom_range(0, 1));
      salt = $urandom;
      wcyc = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, FL));
      ocyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FL - 1)) : -1;
      wv   = int'($urandom_range(0, N - 1));
      wp   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0)
        cfg_write(int'($urandom_range(0, N - 1)), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      run_frame(wcyc, wv, wp, 1'($urandom_range(0, 3) != 0), ocyc);
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset asserted in cycle 5 of a frame
    bus.i_sample_stb = 1'b1;
    tick();
    bus.i_sample_stb = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    rst = 1'b0;
    model_reset();
    repeat (15) begin
      tick();
      chk("midrst_no_valid", 64'(bus.o_mix_valid), 64'd0);
    end
    run_frame(-1, 0, 32'd0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_sinesched.md
# mod_sinesched

Time-multiplexing scheduler that shares one `mod_sinesource` instance between `N_VOICES` oscillator voices. On each sample strobe it walks every voice and presents that voice's phase time and period to the shared source. It accumulates the returned sine values and emits one averaged mix sample per frame. It sits between the sample-rate timebase and the output mixer, and owns all per-voice phase counters and period configuration.

## Interface
Parameters:
- `N_VOICES`, 4: number of voices; power of two, 2..16.
- `VW`, `$clog2(N_VOICES)`: voice index width; derived, do not override.

Ports:
- `i_clk`  in  1: system clock; single clock domain.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_sample_stb`  in  1: one-cycle pulse that starts a frame.
- `i_cfg_we`  in  1: configuration write strobe.
- `i_cfg_voice`  in  VW: voice targeted by the write.
- `i_cfg_period`  in  32 unsigned: period in samples.
- `i_cfg_enable`  in  1: voice enable.
- `o_src_time`  out  64 unsigned: phase time driven to the shared source.
- `o_src_period`  out  32 unsigned: period driven to the shared source; never 0.
- `i_src_sine`  in  32 signed: combinational sine result from the source.
- `o_mix`  out  32 signed: averaged mix sample.
- `o_mix_valid`  out  1: one-cycle pulse when `o_mix` updates.
- `o_busy`  out  1: high while a frame is in progress.
- `o_overrun`  out  1: one-cycle pulse when a strobe is dropped.

## Operation
- Per-voice state:
  - Active: `period[v]` (32b), `enable[v]`, `time[v]` (64b).
  - Shadow: `cfg_period[v]`, `cfg_enable[v]`, `restart[v]`.
- Config write (any state): loads `cfg_period` and `cfg_enable` for `i_cfg_voice`, and sets `restart[v]`. It never disturbs a frame in progress.
- FSM states:
  - IDLE, `o_busy`=0:
    - On `i_sample_stb`: copy shadow to active for all voices. Every voice with `restart` set gets `time`=0, and its `restart` clears.
    - Then clear the accumulator, set `idx`=0, and go to PRESENT.
  - PRESENT:
    - Drive `o_src_time`=`time[idx]`.
    - Drive `o_src_period`=`period[idx]`, or 1 if that period is 0.
    - Go to ACCUM.
  - ACCUM:
    - Operands are held from PRESENT.
    - If the voice is live (`enable[idx]` and `period[idx]`≠0): add sign-extended `i_src_sine` to `acc`, and advance `time[idx]`. Advance means `time`+1, wrapping to 0 when `time`+1 ≥ `period`; `time` always stays below `period`.
    - If the voice is not live: add 0 and leave `time` unchanged.
    - If `idx`=N_VOICES-1, go to DONE; otherwise `idx`+1 and go to PRESENT.
  - DONE:
    - `o_mix` = `acc >>> VW`, truncated to 32b. This is an arithmetic shift: an average, so it cannot overflow.
    - Pulse `o_mix_valid` and go to IDLE.
- `acc` width: 32+VW bits, signed.
- Disabled or zero-period voices still consume their two cycles, so frame length is deterministic.
- `i_sample_stb` outside IDLE: ignored and pulses `o_overrun`. No state change, no frame queued.
- A strobe and a config write to the same voice in the same cycle: the write lands in the shadow after the copy. It takes effect next frame.
- Outside PRESENT/ACCUM, `o_src_time`/`o_src_period` hold their last values.

## Timing
- Reset values:
  - Outputs: `o_src_time`=0, `o_src_period`=1, `o_mix`=0, `o_mix_valid`=0, `o_busy`=0, `o_overrun`=0.
  - Internal: all `time`=0, `period`=0, `enable`=0, `restart`=0, FSM in IDLE.
- Reset mid-frame: abort immediately to reset values. No `o_mix_valid` is issued for the aborted frame.
- Frame latency: strobe sampled in cycle 0, PRESENT of voice 0 in cycle 1, DONE in cycle 2·N_VOICES+1.
  - `o_mix_valid` and the new `o_mix` are registered outputs, visible in cycle 2·N_VOICES+2; that is cycle 10 for N=4.
- `o_busy` is high from cycle 1 through the DONE cycle inclusive.
- Back-to-back: the earliest accepted next strobe is the cycle after DONE. Minimum frame spacing is 2·N_VOICES+2 cycles.
- `i_src_sine` is sampled on the clock edge that ends ACCUM. The source combinational path must close within one cycle from registered `o_src_*`.

## Test plan
- Reset: hold `i_rst` 3 cycles, then check every output's reset value. Idle 20 cycles with no strobe: no `o_mix_valid` and no `o_busy`.
- Single voice: write v0 period 4, enable 1; send 6 strobes spaced 12 cycles.
  - `o_src_time` in v0's PRESENT reads 0,1,2,3,0,1.
  - `o_mix_valid` arrives exactly 10 cycles after each strobe.
  - `o_mix` equals the model's sine/4 (N=4).
- Two voices: v0 period 8, v2 period 3, v1/v3 disabled. Check `o_mix` = (sine(v0)+sine(v2))>>>2 per frame, against a reference model with forced `i_src_sine` = ±262136 extremes.
- Overrun: strobe, then strobe again 4 cycles later.
  - `o_overrun` pulses once.
  - Only one `o_mix_valid`.
  - Voice times advance by exactly 1.
- Mid-frame config: write v1 period 5 during cycle 3 of a frame. The current frame still uses the old v1 values. The next frame presents v1 with time 0 and period 5.
- Zero period and reset: enable v3 with period 0. `o_src_period` reads 1 in its slot, and v3 contributes 0. Then assert `i_rst` in cycle 5 of a frame: outputs return to reset values and no `o_mix_valid` pulses.
